// File: rtl/pipelined_multiplier.sv
// pipelined_multiplier: element-wise signed fixed-point multiplier array for the
// convolver datapath (KERNEL_SIZE^2 lanes) with valid/ready flow control.
// Optional feature macro: MULT_SATURATE_EN (overflowing lanes clamp instead of wrap).
module pipelined_multiplier #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] result,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]            result_ovf
);

  localparam int unsigned N       = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned W       = DATA_WIDTH;
  localparam int unsigned PW      = 2 * DATA_WIDTH;
  localparam int unsigned RND_SH  = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic [PW:0] RND_VAL = (FRAC_BITS > 0) ? ((PW+1)'(1) << RND_SH) : '0;

  // Round half up, rescale, range-check and narrow one full-width product.
  function automatic logic [W:0] f_scale(input logic [PW-1:0] p);
    logic signed [PW:0]  v;
    logic signed [PW:0]  s;
    logic [PW-W+1:0]     hi;
    logic                ovf;
    logic [W-1:0]        res;
    v   = $signed({p[PW-1], p}) + $signed(RND_VAL);
    s   = v >>> FRAC_BITS;
    hi  = s[PW:W-1];
    ovf = !((&hi) || !(|hi));
    res = s[W-1:0];
`ifdef MULT_SATURATE_EN
    if (ovf) res = s[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {ovf, res};
  endfunction

  logic [LATENCY-1:0] r_vld;
  logic               w_stall;
  logic               w_accept;
  logic [N*PW-1:0]    w_prod;
  logic [N*PW-1:0]    w_src;
  logic [N*W-1:0]     w_res;
  logic [N-1:0]       w_ovf;

  // Global stall: the output stage holds a result nobody is taking.
  assign w_stall   = r_vld[LATENCY-1] && !out_ready;
  assign in_ready  = !w_stall;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_vld[LATENCY-1];

  // Full-precision signed products for every lane.
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < N; i++) begin
      w_prod[i*PW +: PW] = PW'($signed(weights[i*W +: W])) * PW'($signed(pixel_data[i*W +: W]));
    end
  end

  // Rescale every lane of the selected product vector.
  always_comb begin
    w_res = '0;
    w_ovf = '0;
    for (int i = 0; i < N; i++) begin
      {w_ovf[i], w_res[i*W +: W]} = f_scale(w_src[i*PW +: PW]);
    end
  end

  // Valid bits shift together with the data; bubbles move whenever not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_accept;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  if (LATENCY == 1) begin : g_single
    logic [N*W-1:0] r_res;
    logic [N-1:0]   r_ovf;

    assign w_src = w_prod;

    // Single stage: multiply and rescale in one cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_res <= '0;
        r_ovf <= '0;
      end else if (!w_stall) begin
        r_res <= w_res;
        r_ovf <= w_ovf;
      end
    end

    assign result     = r_res;
    assign result_ovf = r_ovf;
  end else begin : g_multi
    logic [N*PW-1:0] r_prod;
    logic [N*W-1:0]  r_res [LATENCY-1];
    logic [N-1:0]    r_ovf [LATENCY-1];

    assign w_src = r_prod;

    // Stage 1 holds raw products; stage 2 the rescaled lanes; the rest delay.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_prod <= '0;
        for (int s = 0; s < LATENCY - 1; s++) begin
          r_res[s] <= '0;
          r_ovf[s] <= '0;
        end
      end else if (!w_stall) begin
        r_prod   <= w_prod;
        r_res[0] <= w_res;
        r_ovf[0] <= w_ovf;
        for (int s = 1; s < LATENCY - 1; s++) begin
          r_res[s] <= r_res[s-1];
          r_ovf[s] <= r_ovf[s-1];
        end
      end
    end

    assign result     = r_res[LATENCY-2];
    assign result_ovf = r_ovf[LATENCY-2];
  end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier (W=16, F=8, K=3, L=2).
// Expected values honour MULT_SATURATE_EN when it is defined.
module tb_pipelined_multiplier;

  localparam int W  = 16;
  localparam int N  = 9;
  localparam int BW = N * W;

`ifdef MULT_SATURATE_EN
  localparam logic [15:0] L0_OVF = 16'h7FFF;
  localparam logic [15:0] L1_OVF = 16'h8000;
`else
  localparam logic [15:0] L0_OVF = 16'hFF00;
  localparam logic [15:0] L1_OVF = 16'h0080;
`endif

  typedef logic [BW+N-1:0] exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] weights;
  logic [BW-1:0] pixel_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] result;
  logic [N-1:0]  result_ovf;

  exp_t q[$];
  exp_t pend;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;

  always #5 clk = ~clk;

  pipelined_multiplier #(
    .DATA_WIDTH (16),
    .KERNEL_SIZE(3),
    .FRAC_BITS  (8),
    .LATENCY    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weights   (weights),
    .pixel_data(pixel_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_ovf(result_ovf)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rep(input logic [15:0] v);
    return {9{v}};
  endfunction

  // Reference lane: exact integer arithmetic, round half up, then wrap or clamp.
  function automatic logic [16:0] ref_lane(input logic [15:0] a, input logic [15:0] b);
    longint     p;
    longint     s;
    logic       ovf;
    logic [15:0] r;
    p   = longint'($signed(a)) * longint'($signed(b));
    s   = (p + 64'sd128) >>> 8;
    ovf = (s > 64'sd32767) || (s < -64'sd32768);
    r   = s[15:0];
`ifdef MULT_SATURATE_EN
    if (ovf) r = (s < 0) ? 16'h8000 : 16'h7FFF;
`endif
    return {ovf, r};
  endfunction

  // Monitor and acceptor: sampled at the falling edge, ahead of the transfer edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: got %h expected no output", {result_ovf, result});
        end else begin
          chk("out_data", 160'({result_ovf, result}), 160'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(pend);
        n_acc++;
      end
    end
  end

  // Present one vector (called just after a rising edge) and hold it until taken.
  task automatic send(input logic [BW-1:0] w, input logic [BW-1:0] x, input exp_t e);
    int t;
    weights    = w;
    pixel_data = x;
    pend       = e;
    in_valid   = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain_queue", 160'(q.size()), 160'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BW-1:0] rw, rx, eres;
    logic [N-1:0]  eovf;
    logic [16:0]   lr;
    logic [15:0]   v;
    int            t;
    int            start_acc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    weights = '0; pixel_data = '0; pend = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_result", 160'(result), 160'(0));
    chk("rst_ovf", 160'(result_ovf), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    @(posedge clk);
    #1;

    // Basic vector plus latency: visible after the second edge, not the first.
    send(rep(16'h0180), rep(16'h0200), {9'h000, rep(16'h0300)});
    @(negedge clk);
    chk("lat_after_k", 160'(out_valid), 160'(0));
    @(negedge clk);
    chk("lat_after_k1", 160'(out_valid), 160'(1));
    @(posedge clk);
    #1;

    // Sign and rounding.
    send(rep(16'hFF00), rep(16'h0100), {9'h000, rep(16'hFF00)});
    send(rep(16'h0001), rep(16'h0080), {9'h000, rep(16'h0001)});
    send(rep(16'hFFFF), rep(16'h0080), {9'h000, rep(16'h0000)});

    // Overflow on lane 0 and lane 1.
    send({128'h0, 16'h7FFF}, {128'h0, 16'h7FFF}, {9'h001, 128'h0, L0_OVF});
    send({112'h0, 16'h8000, 16'h0}, {112'h0, 16'h7FFF, 16'h0}, {9'h002, 112'h0, L1_OVF, 16'h0});
    wait_empty();

    // Backpressure: six distinct vectors, four-cycle stall after the third.
    for (int k = 0; k < 6; k++) begin
      v = 16'((k + 1) << 8);
      if (k == 3) begin
        out_ready  = 1'b0;
        weights    = rep(v);
        pixel_data = rep(16'h0100);
        pend       = {9'h000, rep(v)};
        in_valid   = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", 160'(in_ready), 160'(0));
          chk("stall_out_valid", 160'(out_valid), 160'(1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      send(rep(v), rep(16'h0100), {9'h000, rep(v)});
    end
    wait_empty();

    // Reset with two vectors in flight, an input offered during reset.
    send(rep(16'h0200), rep(16'h0200), {9'h000, rep(16'h0400)});
    send(rep(16'h0300), rep(16'h0100), {9'h000, rep(16'h0300)});
    reset      = 1'b1;
    weights    = rep(16'h0500);
    pixel_data = rep(16'h0100);
    pend       = {9'h000, rep(16'h0500)};
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 160'(out_valid), 160'(0));
    chk("midrst_result", 160'(result), 160'(0));
    chk("midrst_ovf", 160'(result_ovf), 160'(0));
    @(posedge clk);
    #1;
    send(rep(16'h0100), rep(16'h0700), {9'h000, rep(16'h0700)});
    @(negedge clk);
    chk("post_rst_k", 160'(out_valid), 160'(0));
    @(negedge clk);
    chk("post_rst_k1", 160'(out_valid), 160'(1));
    @(negedge clk);
    chk("post_rst_alone", 160'(out_valid), 160'(0));
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    start_acc = n_acc;
    t = 0;
    while ((n_acc - start_acc) < 10000 && t < 60000) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          rw[i*W +: W] = 16'($urandom());
          rx[i*W +: W] = 16'($urandom());
        end else begin
          rw[i*W +: W] = 16'($urandom_range(0, 2047)) - 16'd1024;
          rx[i*W +: W] = 16'($urandom_range(0, 2047)) - 16'd1024;
        end
        lr = ref_lane(rw[i*W +: W], rx[i*W +: W]);
        eres[i*W +: W] = lr[15:0];
        eovf[i]        = lr[16];
      end
      weights    = rw;
      pixel_data = rx;
      pend       = {eovf, eres};
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      t++;
    end
    chk("random_count", 160'(n_acc - start_acc), 160'(10000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
